// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with two-word (8-byte) blocks.
// Lookup and miss requests are purely combinational; the only state is the
// frame array, written when memory answers an outstanding block request.
module icache #(
  parameter int NUM_SETS  = 8,
  parameter int ADDR_BITS = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  output logic                 DUT_error,
  input  logic                 icache_REN,
  input  logic [31:0]          icache_addr,
  input  logic                 icache_halt,
  output logic                 icache_hit,
  output logic [31:0]          icache_load,
  output logic                 imem_REN,
  output logic [ADDR_BITS-4:0] imem_block_addr,
  input  logic                 imem_hit,
  input  logic [1:0][31:0]     imem_load
);

  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS = ADDR_BITS - 3 - IDX_BITS;

  // Frame storage: valid bit, tag and both words of the block.
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q  [NUM_SETS];
  logic [TAG_BITS-1:0] tag_d  [NUM_SETS];
  logic [1:0][31:0]    data_q [NUM_SETS];
  logic [1:0][31:0]    data_d [NUM_SETS];

  // Address decomposition; byte-offset and upper bits carry no meaning here.
  logic [IDX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic                word_off;
  logic                unused_addr_bits;

  assign idx              = icache_addr[3 +: IDX_BITS];
  assign tag              = icache_addr[3 + IDX_BITS +: TAG_BITS];
  assign word_off         = icache_addr[2];
  assign unused_addr_bits = ^{icache_addr[31:ADDR_BITS], icache_addr[1:0]};

  logic req;
  logic hit;
  logic fill;

  // Outputs are gated by nRST so they fall to zero the instant reset asserts,
  // without waiting for the cleared valid bits to propagate.
  assign req  = icache_REN & ~icache_halt & nRST;
  assign hit  = req & valid_q[idx] & (tag_q[idx] == tag);
  assign fill = imem_REN & imem_hit;

  // Core- and memory-side outputs: hit data, miss request, protocol error.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    icache_hit      = 1'b0;
    icache_load     = 32'h0;
    imem_REN        = 1'b0;
    imem_block_addr = '0;
    DUT_error       = 1'b0;
    if (hit) begin
      icache_hit  = 1'b1;
      icache_load = data_q[idx][word_off];
    end
    if (req && !hit) begin
      imem_REN        = 1'b1;
      imem_block_addr = icache_addr[ADDR_BITS-1:3];
    end
    // A response with no outstanding request is flagged and never written.
    DUT_error = imem_hit & ~imem_REN & nRST;
  end

  // Next frame contents: a returned block overwrites whatever occupied idx.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill) begin
      valid_d[idx] = 1'b1;
      tag_d[idx]   = tag;
      data_d[idx]  = imem_load;
    end
  end

  // Frame array register; the whole array clears on reset.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: the storage is a small flop array, not an SRAM macro, so clearing
    // it on reset is cheap and makes reset contents deterministic.
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected outputs into a queue,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_icache;

  logic            CLK;
  logic            nRST;
  logic            DUT_error;
  logic            icache_REN;
  logic [31:0]     icache_addr;
  logic            icache_halt;
  logic            icache_hit;
  logic [31:0]     icache_load;
  logic            imem_REN;
  logic [12:0]     imem_block_addr;
  logic            imem_hit;
  logic [1:0][31:0] imem_load;

  icache #(.NUM_SETS(8), .ADDR_BITS(16)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .DUT_error       (DUT_error),
    .icache_REN      (icache_REN),
    .icache_addr     (icache_addr),
    .icache_halt     (icache_halt),
    .icache_hit      (icache_hit),
    .icache_load     (icache_load),
    .imem_REN        (imem_REN),
    .imem_block_addr (imem_block_addr),
    .imem_hit        (imem_hit),
    .imem_load       (imem_load)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] load;
    logic        ren;
    logic [12:0] baddr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push_exp(input string name, input logic h, input logic [31:0] ld,
                          input logic r, input logic [12:0] ba, input logic e);
    exp_t x;
    x.name = name; x.hit = h; x.load = ld; x.ren = r; x.baddr = ba; x.err = e;
    exp_q.push_back(x);
  endtask

  // Monitor: compare every pending expectation against the settled outputs.
  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      checks++;
      if (icache_hit !== x.hit || icache_load !== x.load || imem_REN !== x.ren ||
          imem_block_addr !== x.baddr || DUT_error !== x.err) begin
        failures++;
        $display("FAIL %s: got hit=%0b load=%h ren=%0b baddr=%h err=%0b, want hit=%0b load=%h ren=%0b baddr=%h err=%0b",
                 x.name, icache_hit, icache_load, imem_REN, imem_block_addr, DUT_error,
                 x.hit, x.load, x.ren, x.baddr, x.err);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ren, input logic [31:0] addr, input logic halt,
                       input logic mhit, input logic [31:0] w0, input logic [31:0] w1);
    icache_REN   = ren;
    icache_addr  = addr;
    icache_halt  = halt;
    imem_hit     = mhit;
    imem_load[0] = w0;
    imem_load[1] = w1;
  endtask

  // Shorthands for the three common outcomes.
  task automatic exp_miss(input string name, input logic [12:0] ba);
    push_exp(name, 1'b0, 32'h0, 1'b1, ba, 1'b0);
  endtask
  task automatic exp_hit(input string name, input logic [31:0] ld);
    push_exp(name, 1'b1, ld, 1'b0, 13'h0, 1'b0);
  endtask
  task automatic exp_zero(input string name);
    push_exp(name, 1'b0, 32'h0, 1'b0, 13'h0, 1'b0);
  endtask

  initial begin
    nRST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    exp_zero("reset_all_zero");

    // Release reset and idle.
    step(); nRST = 1'b1; exp_zero("idle_1");
    step(); exp_zero("idle_2");

    // Cold miss on 0x44 (idx 0, tag 1, word 1), fill, then hit both words.
    step(); drive(1, 32'h0000_0044, 0, 0, 32'h0, 32'h0); exp_miss("cold_miss_44", 13'h008);
    step(); drive(1, 32'h0000_0044, 0, 1, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    exp_miss("fill_cycle_no_bypass", 13'h008);
    step(); drive(1, 32'h0000_0044, 0, 0, 32'h0, 32'h0); exp_hit("hit_44_word1", 32'hBBBB_BBBB);
    step(); drive(1, 32'h0000_0040, 0, 0, 32'h0, 32'h0); exp_hit("hit_40_word0", 32'hAAAA_AAAA);
    // Byte-offset and upper address bits are ignored.
    step(); drive(1, 32'hFFFF_0047, 0, 0, 32'h0, 32'h0); exp_hit("hit_ignored_bits", 32'hBBBB_BBBB);

    // Conflict: 0x84 shares index 0 with tag 2.
    step(); drive(1, 32'h0000_0084, 0, 0, 32'h0, 32'h0); exp_miss("conflict_miss_84", 13'h010);
    step(); drive(1, 32'h0000_0084, 0, 1, 32'hCCCC_CCCC, 32'hDDDD_DDDD);
    exp_miss("conflict_fill_84", 13'h010);
    step(); drive(1, 32'h0000_0084, 0, 0, 32'h0, 32'h0); exp_hit("hit_84", 32'hDDDD_DDDD);
    step(); drive(1, 32'h0000_0044, 0, 0, 32'h0, 32'h0); exp_miss("evicted_44", 13'h008);
    step(); drive(1, 32'h0000_0044, 0, 1, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    exp_miss("refill_44", 13'h008);
    step(); drive(1, 32'h0000_0040, 0, 0, 32'h0, 32'h0); exp_hit("rehit_40", 32'hAAAA_AAAA);

    // Different frame (0x58: idx 3, tag 1) leaves frame 0 alone.
    step(); drive(1, 32'h0000_0058, 0, 1, 32'hEEEE_EEEE, 32'hFFFF_FFFF);
    exp_miss("miss_58_idx3", 13'h00B);
    step(); drive(1, 32'h0000_0058, 0, 0, 32'h0, 32'h0); exp_hit("hit_58", 32'hEEEE_EEEE);
    step(); drive(1, 32'h0000_0044, 0, 0, 32'h0, 32'h0); exp_hit("frame0_kept", 32'hBBBB_BBBB);

    // Halt suppresses hit and request; contents survive.
    step(); drive(1, 32'h0000_0044, 1, 0, 32'h0, 32'h0); exp_zero("halt_forces_zero");
    step(); drive(1, 32'h0000_0044, 0, 0, 32'h0, 32'h0); exp_hit("after_halt_hit", 32'hBBBB_BBBB);

    // Unsolicited memory response: flagged, ignored.
    step(); drive(0, 32'h0000_0088, 0, 1, 32'h1111_1111, 32'h2222_2222);
    push_exp("unsolicited_err", 1'b0, 32'h0, 1'b0, 13'h0, 1'b1);
    step(); drive(1, 32'h0000_0088, 0, 0, 32'h0, 32'h0); exp_miss("no_write_on_err", 13'h011);
    step(); drive(1, 32'h0000_0044, 0, 0, 32'h0, 32'h0); exp_hit("err_cache_intact", 32'hBBBB_BBBB);
    // Halted core with memory response: no request, so also an error, no fill.
    step(); drive(1, 32'h0000_0088, 1, 1, 32'h5555_5555, 32'h6666_6666);
    push_exp("halt_resp_err", 1'b0, 32'h0, 1'b0, 13'h0, 1'b1);
    // Legitimate response on a miss: no error.
    step(); drive(1, 32'h0000_0088, 0, 1, 32'h3333_3333, 32'h4444_4444);
    exp_miss("legit_resp_no_err", 13'h011);
    step(); drive(1, 32'h0000_0088, 0, 0, 32'h0, 32'h0); exp_hit("hit_88", 32'h3333_3333);

    // Reset in the middle of a miss: outputs fall before any clock edge.
    step(); drive(1, 32'h0000_00C4, 0, 0, 32'h0, 32'h0); exp_miss("miss_c4", 13'h018);
    step(); nRST = 1'b0; exp_zero("async_reset_mid_miss");
    step(); nRST = 1'b1; drive(1, 32'h0000_0044, 0, 0, 32'h0, 32'h0);
    exp_miss("post_reset_miss_44", 13'h008);
    step(); drive(1, 32'h0000_0088, 0, 0, 32'h0, 32'h0); exp_miss("post_reset_miss_88", 13'h011);
    step(); drive(0, 32'h0, 0, 0, 32'h0, 32'h0); exp_zero("final_idle");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
